// File: rtl/mii_pkg.sv
// MII character codes, CRC-32 constants and the receive FSM state shared by the MAC rx path.
package mii_pkg;
    localparam logic [7:0]  IDLE_CODE     = 8'h07;
    localparam logic [7:0]  START_CODE    = 8'hFB;
    localparam logic [7:0]  TERM_CODE     = 8'hFD;
    localparam logic [7:0]  PREAMBLE_CODE = 8'h55;
    localparam logic [7:0]  SFD_CODE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, DATA, DROP} rx_state_e;

    function automatic logic [15:0] strip_fcs(input logic [15:0] total);
        return (total < 16'd4) ? 16'd0 : total - 16'd4;
    endfunction
endpackage

// File: rtl/crc32_d64.sv
// Reflected CRC-32 over up to eight bytes per cycle; be must be contiguous from lane 0.
module crc32_d64
    import mii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [63:0] data,
    input  logic [7:0]  be,
    output logic [31:0] crc_nxt
);
    logic [31:0] crc_q;

    always_comb begin
        crc_nxt = crc_q;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    crc_nxt = crc_nxt ^ {24'd0, data[8*i +: 8]};
                    for (int b = 0; b < 8; b++)
                        crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ CRC_POLY) : (crc_nxt >> 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   crc_q <= '1;
        else if (clr) crc_q <= '1;
        else          crc_q <= crc_nxt;
    end
endmodule

// File: rtl/mac_mii_rx.sv
// MII receive MAC: frame delineation, preamble/FCS strip, CRC and length check, header decode.
module mac_mii_rx
    import mii_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = 8,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_mii_data,
    input  logic [CTRL_WIDTH-1:0] i_mii_valid,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic [CTRL_WIDTH-1:0] o_rx_keep,
    output logic                  o_rx_valid,
    output logic                  o_rx_last,
    output logic                  o_rx_error,
    output logic [47:0]           o_dest_address,
    output logic [47:0]           o_src_address,
    output logic [15:0]           o_eth_type,
    output logic                  o_hdr_valid,
    output logic [15:0]           o_rx_length,
    output logic                  o_frame_done,
    output logic                  o_fcs_error,
    output logic                  o_frame_error
);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

    rx_state_e             state;
    logic [DATA_WIDTH-1:0] d_r, held;
    logic [CTRL_WIDTH-1:0] c_r, pend_keep, crc_be, keep_last, keep_tail;
    logic                  held_vld, pend, pend_fcs, pend_frm;
    logic [15:0]           len_q, total, pend_len;
    logic [16:0]           sum;
    logic [2:0]            term_k;
    logic                  is_start, pre_ok, is_full, is_term, has_fd, all_idle, idle_above;
    logic                  crc_clr, crc_en, hdr_fire, fcs_bad, len_bad;
    logic [31:0]           crc_nxt;

    always_comb begin
        is_start   = (c_r == 8'h01) && (d_r[7:0] == START_CODE);
        pre_ok     = d_r[63:8] == {SFD_CODE, {6{PREAMBLE_CODE}}};
        is_full    = (c_r == '0);
        term_k     = '0;
        for (int i = CTRL_WIDTH - 1; i >= 0; i--)
            if (c_r[i]) term_k = 3'(i);
        has_fd     = 1'b0;
        all_idle   = (c_r == '1);
        idle_above = 1'b1;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (c_r[i] && d_r[8*i +: 8] == TERM_CODE) has_fd = 1'b1;
            if (d_r[8*i +: 8] != IDLE_CODE) all_idle = 1'b0;
            if (i > int'(term_k) && d_r[8*i +: 8] != IDLE_CODE) idle_above = 1'b0;
        end
        // terminate: first control lane is FD and every lane above it is an idle control
        is_term   = !is_full && (c_r == (8'hFF << term_k)) &&
                    (d_r[8*term_k +: 8] == TERM_CODE) && idle_above;
        sum       = {1'b0, len_q} + (is_full ? 17'd8 : {14'd0, term_k});
        total     = sum[16] ? 16'hFFFF : sum[15:0];
        crc_clr   = (state != DATA);
        crc_en    = (state == DATA) && (is_full || is_term);
        crc_be    = is_full ? '1 : ~c_r;
        fcs_bad   = (crc_nxt != CRC_RESIDUE);
        len_bad   = (total < MIN_LEN) || (total > MAX_LEN);
        // word 1 sits in held while word 2 (bytes 8..15) is decoded
        hdr_fire  = (state == DATA) && (len_q == 16'd8) && (is_full || (is_term && term_k >= 3'd6));
        keep_last = (term_k == 3'd4) ? 8'hFF : (8'h01 << (term_k + 3'd4)) - 8'd1;
        keep_tail = (8'h01 << (term_k - 3'd4)) - 8'd1;
    end

    crc32_d64 u_crc (
        .clk    (clk),
        .rst_n  (i_rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .data   (d_r),
        .be     (crc_be),
        .crc_nxt(crc_nxt)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            d_r <= '0; c_r <= '0; held <= '0; held_vld <= 1'b0; len_q <= '0;
            pend <= 1'b0; pend_keep <= '0; pend_fcs <= 1'b0; pend_frm <= 1'b0; pend_len <= '0;
            o_rx_data <= '0; o_rx_keep <= '0; o_rx_valid <= 1'b0; o_rx_last <= 1'b0; o_rx_error <= 1'b0;
            o_dest_address <= '0; o_src_address <= '0; o_eth_type <= '0; o_hdr_valid <= 1'b0;
            o_rx_length <= '0; o_frame_done <= 1'b0; o_fcs_error <= 1'b0; o_frame_error <= 1'b0;
        end else begin
            d_r <= i_mii_data;
            c_r <= i_mii_valid;
            o_rx_valid <= 1'b0; o_rx_last <= 1'b0; o_rx_error <= 1'b0;
            o_frame_done <= 1'b0; o_hdr_valid <= 1'b0; pend <= 1'b0;

            if (pend) begin
                o_rx_valid <= 1'b1; o_rx_last <= 1'b1; o_rx_data <= held; o_rx_keep <= pend_keep;
                o_rx_error <= pend_fcs | pend_frm;
                o_frame_done <= 1'b1; o_fcs_error <= pend_fcs; o_frame_error <= pend_frm;
                o_rx_length <= pend_len;
            end

            if (hdr_fire) begin
                o_hdr_valid    <= 1'b1;
                o_dest_address <= {held[7:0], held[15:8], held[23:16], held[31:24], held[39:32], held[47:40]};
                o_src_address  <= {held[55:48], held[63:56], d_r[7:0], d_r[15:8], d_r[23:16], d_r[31:24]};
                o_eth_type     <= {d_r[39:32], d_r[47:40]};
            end

            case (state)
                IDLE: if (is_start) begin
                    len_q    <= '0;
                    held_vld <= 1'b0;
                    state    <= pre_ok ? DATA : DROP;
                end
                DATA: begin
                    if (is_full) begin
                        if (held_vld) begin
                            o_rx_valid <= 1'b1; o_rx_data <= held; o_rx_keep <= '1;
                        end
                        held <= d_r; held_vld <= 1'b1; len_q <= total;
                    end else if (is_term) begin
                        state    <= IDLE;
                        held_vld <= 1'b0;
                        if (held_vld && term_k > 3'd4) begin
                            // tail bytes spill into a second beat next cycle
                            o_rx_valid <= 1'b1; o_rx_data <= held; o_rx_keep <= '1;
                            held <= d_r; pend <= 1'b1; pend_keep <= keep_tail;
                            pend_fcs <= fcs_bad; pend_frm <= len_bad; pend_len <= strip_fcs(total);
                        end else begin
                            o_rx_valid <= held_vld; o_rx_last <= held_vld; o_rx_data <= held;
                            o_rx_keep <= keep_last; o_rx_error <= held_vld & (fcs_bad | len_bad);
                            o_frame_done <= 1'b1; o_fcs_error <= fcs_bad; o_frame_error <= len_bad;
                            o_rx_length <= strip_fcs(total);
                        end
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: if (has_fd || all_idle) begin
                    state <= IDLE;
                    o_frame_done <= 1'b1; o_fcs_error <= 1'b0; o_frame_error <= 1'b1;
                    o_rx_length <= strip_fcs(len_q);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
